// File: rtl/accel_read_sequencer.sv
// Drives an SPI master to read and check the accelerometer device ID, then issues periodic
// 3-byte X/Y/Z burst reads and publishes each complete burst as one sample.
module accel_read_sequencer #(
  parameter int unsigned SAMPLE_PERIOD = 1_000_000,
  parameter int unsigned TIMEOUT_CLKS  = 100_000,
  parameter int unsigned RETRY_WAIT    = 50_000,
  parameter logic [7:0]  DEVID_EXP     = 8'hAD,
  parameter logic [7:0]  READ_CMD      = 8'h0B,
  parameter logic [7:0]  DEVID_REG     = 8'h00,
  parameter logic [7:0]  XDATA_REG     = 8'h08
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        spi_cs,
  input  logic        spi_cmd_tgl,
  input  logic        spi_load,
  input  logic [15:0] spi_rdata,
  output logic        spi_start,
  output logic [7:0]  spi_cmd,
  output logic [3:0]  spi_nwrite,
  output logic [3:0]  spi_nread,
  output logic [3:0]  spi_idx_reset,
  output logic [7:0]  x_data,
  output logic [7:0]  y_data,
  output logic [7:0]  z_data,
  output logic        sample_valid,
  output logic [7:0]  dev_id,
  output logic        id_ok,
  output logic        id_err,
  output logic        timeout_err
);

  localparam int unsigned PW   = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int unsigned WMAX = (TIMEOUT_CLKS > RETRY_WAIT) ? TIMEOUT_CLKS : RETRY_WAIT;
  localparam int unsigned WW   = $clog2(WMAX + 1);

  localparam logic [PW-1:0] PeriodLast  = PW'(SAMPLE_PERIOD - 1);
  localparam logic [WW-1:0] TimeoutLast = WW'(TIMEOUT_CLKS - 1);
  localparam logic [WW-1:0] RetryLast   = WW'(RETRY_WAIT - 1);

  typedef enum logic [3:0] {
    StIdle,
    StIdReq,
    StIdWait,
    StIdCheck,
    StRetry,
    StPeriodWait,
    StXyzReq,
    StXyzWait,
    StPublish
  } state_e;

  state_e          state_q, state_d;
  logic            start_q, start_d;
  logic [7:0]      cmd_q, cmd_d;
  logic [3:0]      nread_q, nread_d;
  logic [7:0]      x_q, x_d, y_q, y_d, z_q, z_d;
  logic            sv_q, sv_d;
  logic [7:0]      dev_id_q, dev_id_d;
  logic            id_ok_q, id_ok_d;
  logic            id_err_q, id_err_d;
  logic            to_err_q, to_err_d;
  logic [1:0]      byte_idx_q, byte_idx_d;
  logic [2:0][7:0] slot_q, slot_d;
  logic [PW-1:0]   period_q, period_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic            cs_q, load_q, tgl_q;

  logic in_req, in_wait, cs_rise, load_rise, tgl_edge, timed_out;
  logic unused_rdata;

  assign unused_rdata = ^spi_rdata[15:8];

  assign in_req    = state_q inside {StIdReq, StXyzReq};
  assign in_wait   = state_q inside {StIdWait, StXyzWait};
  assign cs_rise   = spi_cs & ~cs_q;
  assign load_rise = spi_load & ~load_q;
  assign tgl_edge  = spi_cmd_tgl ^ tgl_q;
  assign timed_out = (wait_q == TimeoutLast);

  always_comb begin
    state_d    = state_q;
    start_d    = start_q;
    cmd_d      = cmd_q;
    nread_d    = nread_q;
    x_d        = x_q;
    y_d        = y_q;
    z_d        = z_q;
    sv_d       = 1'b0;
    dev_id_d   = dev_id_q;
    id_ok_d    = id_ok_q;
    id_err_d   = id_err_q;
    to_err_d   = to_err_q;
    byte_idx_d = byte_idx_q;
    slot_d     = slot_q;
    period_d   = (period_q == PeriodLast) ? period_q : period_q + 1'b1;

    if (in_wait && load_rise && byte_idx_q != 2'd3) begin
      unique case (byte_idx_q)
        2'd0:    slot_d[0] = spi_rdata[7:0];
        2'd1:    slot_d[1] = spi_rdata[7:0];
        default: slot_d[2] = spi_rdata[7:0];
      endcase
      byte_idx_d = byte_idx_q + 1'b1;
    end

    // After the command byte has shifted out the master expects the register address.
    if ((in_req || in_wait) && tgl_edge) begin
      cmd_d = (state_q inside {StIdReq, StIdWait}) ? DEVID_REG : XDATA_REG;
    end

    unique case (state_q)
      StIdle: begin
        if (enable) state_d = StIdReq;
      end
      StIdReq, StXyzReq: begin
        if (start_q && !spi_cs) begin
          start_d = 1'b0;
          state_d = (state_q == StIdReq) ? StIdWait : StXyzWait;
        end else if (timed_out) begin
          start_d  = 1'b0;
          to_err_d = 1'b1;
          id_ok_d  = 1'b0;
          state_d  = StRetry;
        end else if (!start_q) begin
          // Hold off while the master is still finishing a transaction begun before reset.
          start_d = spi_cs;
        end
      end
      StIdWait, StXyzWait: begin
        if (cs_rise) begin
          state_d = (state_q == StIdWait) ? StIdCheck : StPublish;
        end else if (timed_out) begin
          start_d  = 1'b0;
          to_err_d = 1'b1;
          id_ok_d  = 1'b0;
          state_d  = StRetry;
        end
      end
      StIdCheck: begin
        dev_id_d = slot_q[0];
        if (slot_q[0] == DEVID_EXP) begin
          id_ok_d = 1'b1;
          state_d = StPeriodWait;
        end else begin
          id_ok_d  = 1'b0;
          id_err_d = 1'b1;
          state_d  = StRetry;
        end
      end
      StRetry: begin
        if (wait_q == RetryLast) state_d = enable ? StIdReq : StIdle;
      end
      StPeriodWait: begin
        if (period_q == PeriodLast) state_d = StXyzReq;
        else if (!enable)           state_d = StIdle;
      end
      StPublish: begin
        if (byte_idx_q == 2'd3) begin
          x_d  = slot_q[0];
          y_d  = slot_q[1];
          z_d  = slot_q[2];
          sv_d = 1'b1;
        end else begin
          to_err_d = 1'b1;
        end
        state_d = StPeriodWait;
      end
      default: state_d = StIdle;
    endcase

    if ((state_d == StIdReq || state_d == StXyzReq) && state_d != state_q) begin
      start_d    = spi_cs;
      cmd_d      = READ_CMD;
      nread_d    = (state_d == StIdReq) ? 4'd1 : 4'd3;
      byte_idx_d = 2'd0;
    end
    if (state_d == StXyzReq && state_q != StXyzReq) period_d = '0;

    // Per-state dwell counter; saturates so a long idle never wraps into a false timeout.
    if (state_d != state_q) wait_d = '0;
    else                    wait_d = (wait_q == '1) ? wait_q : wait_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      start_q    <= 1'b0;
      cmd_q      <= 8'h00;
      nread_q    <= 4'd0;
      x_q        <= 8'h00;
      y_q        <= 8'h00;
      z_q        <= 8'h00;
      sv_q       <= 1'b0;
      dev_id_q   <= 8'h00;
      id_ok_q    <= 1'b0;
      id_err_q   <= 1'b0;
      to_err_q   <= 1'b0;
      byte_idx_q <= 2'd0;
      slot_q     <= '0;
      period_q   <= '0;
      wait_q     <= '0;
      cs_q       <= 1'b0;
      load_q     <= 1'b0;
      tgl_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      cmd_q      <= cmd_d;
      nread_q    <= nread_d;
      x_q        <= x_d;
      y_q        <= y_d;
      z_q        <= z_d;
      sv_q       <= sv_d;
      dev_id_q   <= dev_id_d;
      id_ok_q    <= id_ok_d;
      id_err_q   <= id_err_d;
      to_err_q   <= to_err_d;
      byte_idx_q <= byte_idx_d;
      slot_q     <= slot_d;
      period_q   <= period_d;
      wait_q     <= wait_d;
      cs_q       <= spi_cs;
      load_q     <= spi_load;
      tgl_q      <= spi_cmd_tgl;
    end
  end

  assign spi_start     = start_q;
  assign spi_cmd       = cmd_q;
  assign spi_nwrite    = 4'd2;
  assign spi_nread     = nread_q;
  assign spi_idx_reset = 4'd7;
  assign x_data        = x_q;
  assign y_data        = y_q;
  assign z_data        = z_q;
  assign sample_valid  = sv_q;
  assign dev_id        = dev_id_q;
  assign id_ok         = id_ok_q;
  assign id_err        = id_err_q;
  assign timeout_err   = to_err_q;

endmodule

// File: tb/tb_accel_read_sequencer.sv
// Directed bench for accel_read_sequencer: a simple SPI master/slave model answers each
// request and the bench compares against hand-computed values.
module tb_accel_read_sequencer;

  localparam int unsigned SP = 200;
  localparam int unsigned TO = 100;
  localparam int unsigned RW = 50;

  logic        clk = 1'b0;
  logic        rst, enable, spi_cs, spi_cmd_tgl, spi_load;
  logic [15:0] spi_rdata;
  logic        spi_start, sample_valid, id_ok, id_err, timeout_err;
  logic [7:0]  spi_cmd, x_data, y_data, z_data, dev_id;
  logic [3:0]  spi_nwrite, spi_nread, spi_idx_reset;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  int   sv_count = 0;
  int   rise_cyc = 0;
  logic start_prev = 1'b0;

  accel_read_sequencer #(
    .SAMPLE_PERIOD(SP),
    .TIMEOUT_CLKS (TO),
    .RETRY_WAIT   (RW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .spi_cs       (spi_cs),
    .spi_cmd_tgl  (spi_cmd_tgl),
    .spi_load     (spi_load),
    .spi_rdata    (spi_rdata),
    .spi_start    (spi_start),
    .spi_cmd      (spi_cmd),
    .spi_nwrite   (spi_nwrite),
    .spi_nread    (spi_nread),
    .spi_idx_reset(spi_idx_reset),
    .x_data       (x_data),
    .y_data       (y_data),
    .z_data       (z_data),
    .sample_valid (sample_valid),
    .dev_id       (dev_id),
    .id_ok        (id_ok),
    .id_err       (id_err),
    .timeout_err  (timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (sample_valid) sv_count++;
    if (spi_start && !start_prev) rise_cyc = cyc;
    start_prev = spi_start;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (spi_start) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // One master transaction: handshake, command/address bytes, nload received bytes.
  task automatic run_txn(input int nload, input logic [7:0] d0, input logic [7:0] d1,
                         input logic [7:0] d2, output logic [7:0] mosi0,
                         output logic [7:0] mosi1, output logic [3:0] nread, output int cs_up);
    bit         ok;
    logic [7:0] d [3];
    d[0] = d0;
    d[1] = d1;
    d[2] = d2;
    wait_start(ok);
    check("start_seen", 64'(ok), 64'd1);
    nread  = spi_nread;
    spi_cs = 1'b0;
    repeat (2) @(negedge clk);
    check("start_drop", 64'(spi_start), 64'd0);
    mosi0       = spi_cmd;
    spi_cmd_tgl = ~spi_cmd_tgl;
    repeat (2) @(negedge clk);
    mosi1 = spi_cmd;
    for (int i = 0; i < nload; i++) begin
      spi_rdata = {8'h5A, d[i]};
      spi_load  = 1'b1;
      repeat (2) @(negedge clk);
      spi_load = 1'b0;
      repeat (2) @(negedge clk);
    end
    spi_cs = 1'b1;
    cs_up  = cyc;
    repeat (3) @(negedge clk);
  endtask

  logic [7:0] m0, m1;
  logic [3:0] nr;
  int         csr, csr0, r1, r, sv0;
  bit         ok;

  initial begin
    rst         = 1'b1;
    enable      = 1'b0;
    spi_cs      = 1'b1;
    spi_cmd_tgl = 1'b0;
    spi_load    = 1'b0;
    spi_rdata   = 16'h0000;
    repeat (3) @(negedge clk);
    check("rst_start", 64'(spi_start), 64'd0);
    check("rst_cmd", 64'(spi_cmd), 64'd0);
    check("rst_nread", 64'(spi_nread), 64'd0);
    check("rst_const", 64'({spi_nwrite, spi_idx_reset}), 64'h27);
    check("rst_flags", 64'({sample_valid, id_ok, id_err, timeout_err}), 64'd0);
    check("rst_data", 64'({x_data, y_data, z_data, dev_id}), 64'd0);

    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_no_start", 64'(spi_start), 64'd0);
    enable = 1'b1;

    // ID read returns expected ID
    run_txn(1, 8'hAD, 8'h00, 8'h00, m0, m1, nr, csr);
    check("id_nread", 64'(nr), 64'd1);
    check("id_mosi0", 64'(m0), 64'h0B);
    check("id_mosi1", 64'(m1), 64'h00);
    check("id_dev", 64'(dev_id), 64'hAD);
    check("id_ok", 64'({id_ok, id_err}), 64'b10);

    // Two full X/Y/Z bursts and the period between them
    sv0 = sv_count;
    run_txn(3, 8'h12, 8'h34, 8'h56, m0, m1, nr, csr);
    check("xyz_nread", 64'(nr), 64'd3);
    check("xyz_mosi0", 64'(m0), 64'h0B);
    check("xyz_mosi1", 64'(m1), 64'h08);
    check("xyz_sv_count", 64'(sv_count - sv0), 64'd1);
    check("xyz_data1", 64'({x_data, y_data, z_data}), 64'h123456);
    r1  = rise_cyc;
    sv0 = sv_count;
    run_txn(3, 8'h9A, 8'hBC, 8'hDE, m0, m1, nr, csr);
    check("xyz_period", 64'(rise_cyc - r1), 64'(SP));
    check("xyz_sv_count2", 64'(sv_count - sv0), 64'd1);
    check("xyz_data2", 64'({x_data, y_data, z_data}), 64'h9ABCDE);

    // Short burst: only two bytes
    sv0 = sv_count;
    run_txn(2, 8'h11, 8'h22, 8'h33, m0, m1, nr, csr);
    check("short_no_sv", 64'(sv_count - sv0), 64'd0);
    check("short_to_err", 64'(timeout_err), 64'd1);
    check("short_data", 64'({x_data, y_data, z_data}), 64'h9ABCDE);

    // Reset in the middle of a burst while the master still holds CS low
    wait_start(ok);
    check("mid_start_seen", 64'(ok), 64'd1);
    spi_cs = 1'b0;
    repeat (2) @(negedge clk);
    spi_cmd_tgl = ~spi_cmd_tgl;
    spi_rdata   = 16'h5A77;
    spi_load    = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    spi_load = 1'b0;
    @(negedge clk);
    check("rst_mid_outs",
          64'({spi_start, spi_cmd, spi_nread, x_data, y_data, z_data, dev_id,
               id_ok, id_err, timeout_err, sample_valid}), 64'd0);
    check("rst_mid_const", 64'({spi_nwrite, spi_idx_reset}), 64'h27);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("cs_low_hold", 64'(spi_start), 64'd0);
    spi_cs = 1'b1;

    // Wrong ID, retry, then correct ID
    run_txn(1, 8'h00, 8'h00, 8'h00, m0, m1, nr, csr);
    check("bad_nread", 64'(nr), 64'd1);
    check("bad_dev", 64'(dev_id), 64'h00);
    check("bad_flags", 64'({id_ok, id_err}), 64'b01);
    csr0 = csr;
    run_txn(1, 8'hAD, 8'h00, 8'h00, m0, m1, nr, csr);
    check("retry_gap", 64'(rise_cyc - csr0), 64'(RW + 2));
    check("retry_flags", 64'({id_ok, id_err}), 64'b11);
    check("retry_dev", 64'(dev_id), 64'hAD);

    // Master never lowers CS: request times out
    wait_start(ok);
    check("to_start_seen", 64'(ok), 64'd1);
    @(negedge clk);
    r = rise_cyc;
    check("to_err_pre", 64'(timeout_err), 64'd0);
    while (cyc < r + int'(TO) - 1) @(negedge clk);
    check("to_start_held", 64'(spi_start), 64'd1);
    @(negedge clk);
    check("to_start_drop", 64'(spi_start), 64'd0);
    check("to_flags", 64'({timeout_err, id_ok}), 64'b10);
    wait_start(ok);
    check("to_retry_seen", 64'(ok), 64'd1);
    @(negedge clk);
    check("to_retry_gap", 64'(rise_cyc - r), 64'(TO + RW));
    check("to_retry_nread", 64'(spi_nread), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
